// File: rtl/branch_predictor.sv
// Branch predictor: BTB plus 2-bit BHT lookup in fetch, mispredict detection and training in execute.
// Define BP_GSHARE_EN to XOR a non-speculative global history register into the BHT index.
module branch_predictor #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  pc_f_i,
    output logic             pred_taken_f_o,
    output logic [XLEN-1:0]  pred_target_f_o,
    output logic [IDX_W-1:0] pred_idx_f_o,
    input  logic             valid_e_i,
    input  logic             branch_e_i,
    input  logic             jump_e_i,
    input  logic             taken_e_i,
    input  logic [XLEN-1:0]  pc_e_i,
    input  logic [XLEN-1:0]  target_e_i,
    input  logic             pred_taken_e_i,
    input  logic [XLEN-1:0]  pred_target_e_i,
    input  logic [IDX_W-1:0] pred_idx_e_i,
    output logic             mispredict_o,
    output logic [XLEN-1:0]  redirect_pc_o
);

    localparam int unsigned Depth = 1 << IDX_W;
    localparam int unsigned TagW  = XLEN - IDX_W - 2;

    logic [1:0]      bht_q        [Depth];
    logic [1:0]      bht_d        [Depth];
    logic            btb_valid_q  [Depth];
    logic            btb_valid_d  [Depth];
    logic [TagW-1:0] btb_tag_q    [Depth];
    logic [TagW-1:0] btb_tag_d    [Depth];
    logic [XLEN-1:0] btb_target_q [Depth];
    logic [XLEN-1:0] btb_target_d [Depth];
    logic            btb_jump_q   [Depth];
    logic            btb_jump_d   [Depth];

    logic [IDX_W-1:0] idx_f;
    logic [IDX_W-1:0] idx_e;
    logic [TagW-1:0]  tag_f;
    logic [TagW-1:0]  tag_e;
    logic             hit_f;
    logic [1:0]       bht_f;
    logic             ctrl_e;
    logic             unused_bits;

    assign idx_f  = pc_f_i[IDX_W+1:2];
    assign tag_f  = pc_f_i[XLEN-1:IDX_W+2];
    assign idx_e  = pc_e_i[IDX_W+1:2];
    assign tag_e  = pc_e_i[XLEN-1:IDX_W+2];
    assign ctrl_e = branch_e_i | jump_e_i;

    assign unused_bits = ^{pc_f_i[1:0], pc_e_i[1:0], bht_f[0]};

`ifdef BP_GSHARE_EN
    logic [IDX_W-1:0] ghr_q;
    logic [IDX_W-1:0] ghr_d;

    assign pred_idx_f_o = idx_f ^ ghr_q;

    // History only advances on resolved branches, never at fetch.
    always_comb begin
        ghr_d = ghr_q;
        if (valid_e_i && branch_e_i) begin
            ghr_d = {ghr_q[IDX_W-2:0], taken_e_i};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end
`else
    assign pred_idx_f_o = idx_f;
`endif

    // Fetch lookup: BTB is always indexed by PC, the BHT by pred_idx_f_o.
    always_comb begin
        hit_f           = btb_valid_q[idx_f] && (btb_tag_q[idx_f] == tag_f);
        bht_f           = bht_q[pred_idx_f_o];
        pred_taken_f_o  = hit_f && (btb_jump_q[idx_f] || bht_f[1]);
        pred_target_f_o = pred_taken_f_o ? btb_target_q[idx_f] : pc_f_i + XLEN'(4);
    end

    always_comb begin
        mispredict_o = 1'b0;
        if (valid_e_i) begin
            if (ctrl_e) begin
                mispredict_o = (taken_e_i != pred_taken_e_i) ||
                               (taken_e_i && (target_e_i != pred_target_e_i));
            end else begin
                mispredict_o = pred_taken_e_i;
            end
        end
        redirect_pc_o = (ctrl_e && taken_e_i) ? target_e_i : pc_e_i + XLEN'(4);
    end

    always_comb begin
        bht_d        = bht_q;
        btb_valid_d  = btb_valid_q;
        btb_tag_d    = btb_tag_q;
        btb_target_d = btb_target_q;
        btb_jump_d   = btb_jump_q;
        if (valid_e_i) begin
            if (branch_e_i) begin
                if (taken_e_i && (bht_q[pred_idx_e_i] != 2'b11)) begin
                    bht_d[pred_idx_e_i] = bht_q[pred_idx_e_i] + 2'd1;
                end else if (!taken_e_i && (bht_q[pred_idx_e_i] != 2'b00)) begin
                    bht_d[pred_idx_e_i] = bht_q[pred_idx_e_i] - 2'd1;
                end
            end
            if (ctrl_e && taken_e_i) begin
                btb_valid_d[idx_e]  = 1'b1;
                btb_tag_d[idx_e]    = tag_e;
                btb_target_d[idx_e] = target_e_i;
                btb_jump_d[idx_e]   = jump_e_i;
            end else if (!ctrl_e && pred_taken_e_i) begin
                // Non-control instruction aliased onto a BTB entry: drop it.
                btb_valid_d[idx_e] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                bht_q[i]        <= 2'b01;
                btb_valid_q[i]  <= 1'b0;
                btb_tag_q[i]    <= '0;
                btb_target_q[i] <= '0;
                btb_jump_q[i]   <= 1'b0;
            end
        end else begin
            bht_q        <= bht_d;
            btb_valid_q  <= btb_valid_d;
            btb_tag_q    <= btb_tag_d;
            btb_target_q <= btb_target_d;
            btb_jump_q   <= btb_jump_d;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Testbench for branch_predictor: directed vector table, reset sequence and randomized
// stimulus against an arithmetic reference model (gshare parts follow BP_GSHARE_EN).
module tb_branch_predictor;

    localparam int XLEN  = 32;
    localparam int IDX_W = 6;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [XLEN-1:0]   pc_f;
    logic              pred_taken_f;
    logic [XLEN-1:0]   pred_target_f;
    logic [IDX_W-1:0]  pred_idx_f;
    logic              valid_e;
    logic              branch_e;
    logic              jump_e;
    logic              taken_e;
    logic [XLEN-1:0]   pc_e;
    logic [XLEN-1:0]   target_e;
    logic              pred_taken_e;
    logic [XLEN-1:0]   pred_target_e;
    logic [IDX_W-1:0]  pred_idx_e;
    logic              mispredict;
    logic [XLEN-1:0]   redirect_pc;

    always #5 clk = ~clk;

    branch_predictor #(.XLEN(XLEN), .IDX_W(IDX_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pc_f_i          (pc_f),
        .pred_taken_f_o  (pred_taken_f),
        .pred_target_f_o (pred_target_f),
        .pred_idx_f_o    (pred_idx_f),
        .valid_e_i       (valid_e),
        .branch_e_i      (branch_e),
        .jump_e_i        (jump_e),
        .taken_e_i       (taken_e),
        .pc_e_i          (pc_e),
        .target_e_i      (target_e),
        .pred_taken_e_i  (pred_taken_e),
        .pred_target_e_i (pred_target_e),
        .pred_idx_e_i    (pred_idx_e),
        .mispredict_o    (mispredict),
        .redirect_pc_o   (redirect_pc)
    );

    typedef struct {
        logic [31:0] pc_f;
        bit          valid;
        bit          branch;
        bit          jump;
        bit          taken;
        logic [31:0] pc_e;
        logic [31:0] tgt_e;
        bit          pt_e;
        logic [31:0] ptgt_e;
        logic [5:0]  pidx_e;
    } ein_t;

    typedef struct {
        ein_t        in;
        bit          x_pt;
        logic [31:0] x_tgt;
        int          x_idx;
        bit          x_misp;
        logic [31:0] x_redir;
    } vec_t;

    // Reference model: one record per table slot, plain integer counters.
    typedef struct {
        bit          valid;
        logic [31:0] pc;
        logic [31:0] target;
        bit          jump;
    } m_ent_t;

    m_ent_t m_btb [64];
    int     m_bht [64];
    int     m_ghr;

    int n_pass  = 0;
    int n_total = 0;

    function automatic int m_index(input logic [31:0] pc);
        return int'((pc / 4) % 64);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 64; i++) begin
            m_btb[i].valid = 1'b0;
            m_bht[i]       = 1;
        end
        m_ghr = 0;
    endtask

    task automatic m_pred(input logic [31:0] pc, output bit tk, output logic [31:0] tgt,
                          output int idx);
        int b;
        bit hit;
        b   = m_index(pc);
        idx = b;
`ifdef BP_GSHARE_EN
        idx = b ^ m_ghr;
`endif
        hit = m_btb[b].valid && ((m_btb[b].pc / 256) == (pc / 256));
        tk  = hit && (m_btb[b].jump || m_bht[idx] >= 2);
        tgt = tk ? m_btb[b].target : pc + 32'd4;
    endtask

    task automatic m_detect(input ein_t v, output bit misp, output logic [31:0] redir);
        bit ctrl;
        ctrl = v.branch || v.jump;
        if (!v.valid)  misp = 1'b0;
        else if (ctrl) misp = (v.taken != v.pt_e) || (v.taken && v.tgt_e != v.ptgt_e);
        else           misp = v.pt_e;
        redir = (ctrl && v.taken) ? v.tgt_e : v.pc_e + 32'd4;
    endtask

    task automatic m_update(input ein_t v);
        int  b;
        bit  ctrl;
        if (!v.valid) return;
        b    = m_index(v.pc_e);
        ctrl = v.branch || v.jump;
        if (v.branch) begin
            if (v.taken) m_bht[v.pidx_e] = (m_bht[v.pidx_e] < 3) ? m_bht[v.pidx_e] + 1 : 3;
            else         m_bht[v.pidx_e] = (m_bht[v.pidx_e] > 0) ? m_bht[v.pidx_e] - 1 : 0;
            m_ghr = (m_ghr * 2 + int'(v.taken)) % 64;
        end
        if (ctrl && v.taken) begin
            m_btb[b].valid  = 1'b1;
            m_btb[b].pc     = v.pc_e;
            m_btb[b].target = v.tgt_e;
            m_btb[b].jump   = v.jump;
        end else if (!ctrl && v.pt_e) begin
            m_btb[b].valid = 1'b0;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic drive(input ein_t v);
        pc_f          = v.pc_f;
        valid_e       = v.valid;
        branch_e      = v.branch;
        jump_e        = v.jump;
        taken_e       = v.taken;
        pc_e          = v.pc_e;
        target_e      = v.tgt_e;
        pred_taken_e  = v.pt_e;
        pred_target_e = v.ptgt_e;
        pred_idx_e    = v.pidx_e;
    endtask

    function automatic ein_t ein(input logic [31:0] pcf, input bit vl, input bit br,
                                 input bit jp, input bit tk, input logic [31:0] pce,
                                 input logic [31:0] tgt, input bit pt,
                                 input logic [31:0] ptgt);
        ein_t v;
        v.pc_f   = pcf;
        v.valid  = vl;
        v.branch = br;
        v.jump   = jp;
        v.taken  = tk;
        v.pc_e   = pce;
        v.tgt_e  = tgt;
        v.pt_e   = pt;
        v.ptgt_e = ptgt;
        v.pidx_e = 6'(m_index(pce));
        return v;
    endfunction

    function automatic vec_t mk(input ein_t v, input bit xpt, input logic [31:0] xtgt,
                                input int xidx, input bit xm, input logic [31:0] xr);
        vec_t t;
        t.in      = v;
        t.x_pt    = xpt;
        t.x_tgt   = xtgt;
        t.x_idx   = xidx;
        t.x_misp  = xm;
        t.x_redir = xr;
        return t;
    endfunction

    // Drive at posedge+1, sample at negedge, let the model commit after the edge.
    task automatic cycle_model(input ein_t v, input string name);
        bit          xpt;
        bit          xm;
        logic [31:0] xtgt;
        logic [31:0] xr;
        int          xidx;
        drive(v);
        m_pred(v.pc_f, xpt, xtgt, xidx);
        m_detect(v, xm, xr);
        @(negedge clk);
        chk({name, " pred_taken_f"}, 32'(pred_taken_f), 32'(xpt));
        chk({name, " pred_target_f"}, pred_target_f, xtgt);
        chk({name, " pred_idx_f"}, 32'(pred_idx_f), 32'(xidx));
        chk({name, " mispredict"}, 32'(mispredict), 32'(xm));
        chk({name, " redirect_pc"}, redirect_pc, xr);
        @(posedge clk);
        m_update(v);
        #1;
    endtask

    task automatic cycle_exp(input vec_t t, input string name);
        drive(t.in);
        @(negedge clk);
        chk({name, " pred_taken_f"}, 32'(pred_taken_f), 32'(t.x_pt));
        chk({name, " pred_target_f"}, pred_target_f, t.x_tgt);
        chk({name, " pred_idx_f"}, 32'(pred_idx_f), 32'(t.x_idx));
        chk({name, " mispredict"}, 32'(mispredict), 32'(t.x_misp));
        chk({name, " redirect_pc"}, redirect_pc, t.x_redir);
        @(posedge clk);
        m_update(t.in);
        #1;
    endtask

    function automatic logic [31:0] rpc();
        if ($urandom_range(0, 31) == 0) return 32'hFFFF_FFFC;
        return (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2);
    endfunction

    vec_t tbl [16];
    ein_t v;

    initial begin
        rst_n = 1'b0;
        m_reset();
        drive(ein(32'h100, 0, 0, 0, 0, 32'h100, 0, 0, 0));
        #1;
        chk("reset pred_taken_f", 32'(pred_taken_f), 32'd0);
        chk("reset pred_target_f", pred_target_f, 32'h104);
        chk("reset mispredict", 32'(mispredict), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

`ifndef BP_GSHARE_EN
        tbl[0]  = mk(ein(32'h100, 0, 0, 0, 0, 32'h100, 0, 0, 0), 0, 32'h104, 0, 0, 32'h104);
        tbl[1]  = mk(ein(32'h100, 1, 1, 0, 1, 32'h100, 32'h80, 0, 32'h104),
                     0, 32'h104, 0, 1, 32'h80);
        tbl[2]  = mk(ein(32'h100, 1, 1, 0, 1, 32'h100, 32'h80, 1, 32'h80),
                     1, 32'h80, 0, 0, 32'h80);
        tbl[3]  = mk(ein(32'h100, 1, 1, 0, 1, 32'h100, 32'h80, 1, 32'h80),
                     1, 32'h80, 0, 0, 32'h80);
        tbl[4]  = mk(ein(32'h100, 1, 1, 0, 0, 32'h100, 32'h80, 1, 32'h80),
                     1, 32'h80, 0, 1, 32'h104);
        tbl[5]  = mk(ein(32'h100, 0, 0, 0, 0, 32'h100, 0, 0, 0), 1, 32'h80, 0, 0, 32'h104);
        tbl[6]  = mk(ein(32'h200, 1, 0, 1, 1, 32'h200, 32'h400, 0, 32'h204),
                     0, 32'h204, 0, 1, 32'h400);
        tbl[7]  = mk(ein(32'h200, 1, 1, 0, 0, 32'h100, 32'h80, 0, 32'h104),
                     1, 32'h400, 0, 0, 32'h104);
        tbl[8]  = mk(ein(32'h200, 0, 0, 0, 0, 32'h200, 0, 0, 0), 1, 32'h400, 0, 0, 32'h204);
        tbl[9]  = mk(ein(32'h200, 1, 0, 1, 1, 32'h200, 32'h500, 1, 32'h400),
                     1, 32'h400, 0, 1, 32'h500);
        tbl[10] = mk(ein(32'h200, 0, 0, 0, 0, 32'h200, 0, 0, 0), 1, 32'h500, 0, 0, 32'h204);
        tbl[11] = mk(ein(32'h200, 1, 0, 0, 0, 32'h1200, 0, 1, 32'h500),
                     1, 32'h500, 0, 1, 32'h1204);
        tbl[12] = mk(ein(32'h200, 0, 0, 0, 0, 32'h1200, 0, 0, 0), 0, 32'h204, 0, 0, 32'h1204);
        tbl[13] = mk(ein(32'h300, 0, 1, 0, 1, 32'h300, 32'h900, 1, 32'h500),
                     0, 32'h304, 0, 0, 32'h900);
        tbl[14] = mk(ein(32'h300, 0, 0, 0, 0, 32'h300, 0, 0, 0), 0, 32'h304, 0, 0, 32'h304);
        tbl[15] = mk(ein(32'hFFFF_FFFC, 1, 0, 0, 0, 32'hFFFF_FFFC, 0, 0, 0),
                     0, 32'h0, 63, 0, 32'h0);
        for (int i = 0; i < 16; i++) cycle_exp(tbl[i], $sformatf("tbl%0d", i));
`endif

        // Reset asserted while an update is pending: the update must be discarded.
        cycle_model(ein(32'h40, 1, 0, 1, 1, 32'h40, 32'h800, 0, 32'h44), "jal40");
        drive(ein(32'h40, 0, 0, 0, 0, 32'h40, 0, 0, 0));
        @(negedge clk);
        chk("pre-reset hit pred_taken_f", 32'(pred_taken_f), 32'd1);
        chk("pre-reset hit pred_target_f", pred_target_f, 32'h800);
        @(posedge clk);
        #1;
        drive(ein(32'h40, 1, 1, 0, 1, 32'h44, 32'h900, 0, 32'h48));
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("in-reset pred_taken_f", 32'(pred_taken_f), 32'd0);
        chk("in-reset pred_target_f", pred_target_f, 32'h44);
        chk("in-reset pred_idx_f", 32'(pred_idx_f), 32'd16);
        chk("in-reset mispredict", 32'(mispredict), 32'd1);
        chk("in-reset redirect_pc", redirect_pc, 32'h900);
        @(posedge clk);
        #1;
        m_reset();
        rst_n = 1'b1;
        drive(ein(32'h44, 0, 0, 0, 0, 32'h44, 0, 0, 0));
        @(negedge clk);
        chk("post-reset dropped update", 32'(pred_taken_f), 32'd0);
        chk("post-reset target", pred_target_f, 32'h48);
        @(posedge clk);
        #1;
        cycle_model(ein(32'h40, 1, 1, 0, 1, 32'h40, 32'h800, 0, 32'h44), "br40");
`ifndef BP_GSHARE_EN
        drive(ein(32'h40, 0, 0, 0, 0, 32'h40, 0, 0, 0));
        @(negedge clk);
        chk("counter 01->10 taken", 32'(pred_taken_f), 32'd1);
        @(posedge clk);
        #1;
`else
        cycle_model(ein(32'h10, 1, 1, 0, 1, 32'h10, 32'h20, 0, 32'h14), "gs1");
        cycle_model(ein(32'h10, 1, 1, 0, 0, 32'h10, 32'h20, 0, 32'h14), "gs2");
        drive(ein(32'h100, 0, 0, 0, 0, 32'h100, 0, 0, 0));
        @(negedge clk);
        chk("ghr 000110 pred_idx_f", 32'(pred_idx_f), 32'h06);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ghr cleared pred_idx_f", 32'(pred_idx_f), 32'h00);
        chk("ghr cleared pred_taken_f", 32'(pred_taken_f), 32'd0);
        @(posedge clk);
        #1;
        m_reset();
        rst_n = 1'b1;
`endif

        for (int i = 0; i < 2000; i++) begin
            bit          pt;
            logic [31:0] ptgt;
            int          pidx;
            int          kind;
            kind     = int'($urandom_range(0, 2));
            v.pc_f   = rpc();
            v.pc_e   = rpc();
            v.valid  = ($urandom_range(0, 9) != 0);
            v.branch = (kind == 0);
            v.jump   = (kind == 1);
            v.taken  = v.jump ? 1'b1 : 1'($urandom_range(0, 1));
            v.tgt_e  = rpc();
            m_pred(v.pc_e, pt, ptgt, pidx);
            if ($urandom_range(0, 4) == 0) pt = ~pt;
            v.pt_e   = pt;
            v.ptgt_e = ($urandom_range(0, 7) == 0) ? rpc() : ptgt;
            v.pidx_e = 6'(pidx);
            cycle_model(v, $sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
